joypad_port: RTL and testbench

Standard-controller responder on the k6502 CPU bus at $4016/$4017. Decodes the address and rw the core drives, captures the strobe on writes to $4016, and returns controller state one bit per read through 8-bit parallel-load/serial-shift registers. It sits beside the RAM/ROM decoders as a bus target; its read data is merged into the core's external d bus.

---
 rtl/joypad_port_pkg.sv | 24 ++
 rtl/joypad_shift.sv | 37 +++
 rtl/joypad_port.sv | 95 +++++++++
 tb/tb_joypad_port.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/joypad_port_pkg.sv
// Shared bus definitions for the $4016/$4017 controller ports: addresses, open-bus
// bits, and the R/W encoding the core drives.
package joypad_port_pkg;

    localparam logic [15:0] JOY1_ADDR    = 16'h4016;
    localparam logic [15:0] JOY2_ADDR    = 16'h4017;
    localparam logic [2:0]  JOY_OPEN_BUS = 3'b010;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_JOY1_RD,
        ACC_JOY2_RD,
        ACC_JOY1_WR
    } joy_acc_e;

    // Open-bus value for bits 7:5, with the serial controller bit in bit 0.
    function automatic logic [7:0] joy_rdata(input logic serial_bit);
        return {JOY_OPEN_BUS, 4'b0000, serial_bit};
    endfunction

endpackage

// File: rtl/joypad_shift.sv
// One controller port: pad synchronizer plus an 8-bit parallel-load / serial-shift register.
// load has priority over shift; each shift pulls a 1 in at bit 7, so the register fills with 1s.
module joypad_shift #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pad,
    input  logic       load,
    input  logic       shift,
    output logic       bit_out
);

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]                  sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= 8'h00;
        end else if (load) begin
            sr <= sync_q[SYNC_STAGES-1];
        end else if (shift) begin
            sr <= {1'b1, sr[7:1]};
        end
    end

    assign bit_out = sr[0];

endmodule

// File: rtl/joypad_port.sv
// Standard-controller bus target at $4016/$4017: address decode, strobe register, read-data mux.
// Port 2 is built only when JOYPAD_PORT2_EN is defined; otherwise $4017 reads return open bus.
module joypad_port #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        rw,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic [7:0]  pad1,
    input  logic [7:0]  pad2
);

    import joypad_port_pkg::*;

    joy_acc_e acc;
    logic     strobe;
    logic     bit1;
    logic     bit2;
    logic     d_in_unused;

    always_comb begin
        acc = ACC_NONE;
        if (rw == RW_READ && a == JOY1_ADDR) begin
            acc = ACC_JOY1_RD;
        end else if (rw == RW_READ && a == JOY2_ADDR) begin
            acc = ACC_JOY2_RD;
        end else if (rw == RW_WRITE && a == JOY1_ADDR) begin
            acc = ACC_JOY1_WR;
        end
    end

    // $4017 writes belong to the APU frame counter and never touch strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe <= 1'b0;
        end else if (acc == ACC_JOY1_WR) begin
            strobe <= d_in[0];
        end
    end

    assign d_in_unused = ^d_in[7:1];

    // Loading keys off the current strobe, so the clearing write still performs one last load.
    joypad_shift #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shift1 (
        .clk     (clk),
        .rst     (rst),
        .pad     (pad1),
        .load    (strobe),
        .shift   ((acc == ACC_JOY1_RD) && !strobe),
        .bit_out (bit1)
    );

`ifdef JOYPAD_PORT2_EN
    joypad_shift #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shift2 (
        .clk     (clk),
        .rst     (rst),
        .pad     (pad2),
        .load    (strobe),
        .shift   ((acc == ACC_JOY2_RD) && !strobe),
        .bit_out (bit2)
    );
`else
    logic pad2_unused;
    assign pad2_unused = ^pad2;
    assign bit2        = 1'b0;
`endif

    always_comb begin
        d_out = 8'h00;
        d_oe  = 1'b0;
        case (acc)
            ACC_JOY1_RD: begin
                d_oe  = 1'b1;
                d_out = joy_rdata(bit1);
            end
            ACC_JOY2_RD: begin
                d_oe  = 1'b1;
                d_out = joy_rdata(bit2);
            end
            default: begin
                d_out = 8'h00;
                d_oe  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_joypad_port.sv
// Directed vector bench for joypad_port; $4017 expectations follow JOYPAD_PORT2_EN.
module tb_joypad_port;

`ifdef JOYPAD_PORT2_EN
    localparam bit P2 = 1'b1;
`else
    localparam bit P2 = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = 16'h5000;
    logic        rw = 1'b1;
    logic [7:0]  d_in = 8'h00;
    logic [7:0]  d_out;
    logic        d_oe;
    logic [7:0]  pad1 = 8'h00;
    logic [7:0]  pad2 = 8'h00;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
        logic [7:0]  p1;
        logic [7:0]  p2;
        logic [7:0]  exp_d;
        logic        exp_oe;
    } vec_t;

    vec_t vecs[$];

    joypad_port #(.SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .rw    (rw),
        .d_in  (d_in),
        .d_out (d_out),
        .d_oe  (d_oe),
        .pad1  (pad1),
        .pad2  (pad2)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] p2v(input logic [7:0] v);
        return P2 ? v : 8'h40;
    endfunction

    task automatic add(input logic [15:0] va, input logic vrw, input logic [7:0] vd,
                       input logic [7:0] vp1, input logic [7:0] vp2,
                       input logic [7:0] ed, input logic eoe);
        vec_t v;
        v.a = va; v.rw = vrw; v.d = vd; v.p1 = vp1; v.p2 = vp2;
        v.exp_d = ed; v.exp_oe = eoe;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] ed, input logic eoe);
        n_vec++;
        if (d_out !== ed || d_oe !== eoe) begin
            n_bad++;
            $display("FAIL %s: d_out=%h d_oe=%b, required d_out=%h d_oe=%b",
                     name, d_out, d_oe, ed, eoe);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(posedge clk);
        #1;
        a = v.a; rw = v.rw; d_in = v.d; pad1 = v.p1; pad2 = v.p2;
        @(negedge clk);
        check(name, v.exp_d, v.exp_oe);
    endtask

    // Strobe cycle: three writes of 1 then a clearing write, all on $4016.
    task automatic add_strobe(input logic [7:0] p1, input logic [7:0] p2);
        for (int k = 0; k < 3; k++) add(16'h4016, 1'b0, 8'h01, p1, p2, 8'h00, 1'b0);
        add(16'h4016, 1'b0, 8'h00, p1, p2, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] seq_exp [10];
        vec_t       rv;

        // Reset state
        #2;
        check("rst_other_addr", 8'h00, 1'b0);
        a = 16'h4016; rw = 1'b1;
        #1;
        check("rst_read4016", 8'h40, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        a = 16'h5000; rw = 1'b1;

        add(16'h4016, 1'b1, 8'h00, 8'h00, 8'h00, 8'h40, 1'b1);
        add(16'h5000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(16'h4016, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        add(16'h4017, 1'b1, 8'h00, 8'h00, 8'h00, 8'h40, 1'b1);
        add(16'h4017, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);

        // pad1 = 1000_0101: serial order A first, then 1s once emptied
        add(16'h5000, 1'b0, 8'h01, 8'h85, 8'h00, 8'h00, 1'b0);
        add(16'h4016, 1'b0, 8'h01, 8'h85, 8'h00, 8'h00, 1'b0);
        add_strobe(8'h85, 8'h00);
        seq_exp = '{8'h41, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};
        for (int k = 0; k < 10; k++) add(16'h4016, 1'b1, 8'h00, 8'h85, 8'h00, seq_exp[k], 1'b1);

        // Strobe high: reads return A without shifting; clearing write then one read
        add(16'h4016, 1'b0, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) add(16'h4016, 1'b1, 8'h00, 8'h01, 8'h00, 8'h41, 1'b1);
        add(16'h4016, 1'b0, 8'h00, 8'h01, 8'h00, 8'h00, 1'b0);
        add(16'h4016, 1'b1, 8'h00, 8'h01, 8'h00, 8'h41, 1'b1);
        add(16'h4016, 1'b1, 8'h00, 8'h01, 8'h00, 8'h40, 1'b1);

        // Interleaved ports
        add_strobe(8'h01, 8'h02);
        add(16'h4016, 1'b1, 8'h00, 8'h01, 8'h02, 8'h41, 1'b1);
        add(16'h4017, 1'b1, 8'h00, 8'h01, 8'h02, p2v(8'h40), 1'b1);
        add(16'h4016, 1'b1, 8'h00, 8'h01, 8'h02, 8'h40, 1'b1);
        add(16'h4017, 1'b1, 8'h00, 8'h01, 8'h02, p2v(8'h41), 1'b1);

        // pad2 all pressed: port 2 reads 1s, or open bus without port 2
        add_strobe(8'h01, 8'hFF);
        add(16'h4017, 1'b1, 8'h00, 8'h01, 8'hFF, p2v(8'h41), 1'b1);
        add(16'h4017, 1'b1, 8'h00, 8'h01, 8'hFF, p2v(8'h41), 1'b1);

        // Setup for mid-sequence reset: load all 1s, shift 3 times
        add_strobe(8'hFF, 8'hFF);
        for (int k = 0; k < 3; k++) add(16'h4016, 1'b1, 8'h00, 8'hFF, 8'hFF, 8'h41, 1'b1);

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-read: register clears without a clock edge
        @(posedge clk);
        #1;
        rst = 1'b1;
        a = 16'h4016; rw = 1'b1;
        #1;
        check("rst_async_clear", 8'h40, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        a = 16'h5000; rw = 1'b0;

        // Eight zeros shift out, then the fill 1 reaches bit 0
        rv.a = 16'h4016; rv.rw = 1'b1; rv.d = 8'h00; rv.p1 = 8'hFF; rv.p2 = 8'hFF; rv.exp_oe = 1'b1;
        for (int k = 0; k < 9; k++) begin
            rv.exp_d = (k < 8) ? 8'h40 : 8'h41;
            apply(rv, $sformatf("post_rst_read%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
